// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment serial output path.
// Holds the shifter FSM state encoding, the native frame width of the
// 8-digit segment decoder and the default serial-clock divider.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } seg_state_t;

  // 8 digits x 8 segment lines, active-low
  localparam int SEG_FRAME_W = 64;

  // System cycles per serial-clock half-period
  localparam int SEG_DIV_DEF = 2;

endpackage

// File: rtl/seg_serial_out_phase_ctr.sv
// seg_phase_ctr: bit-period phase counter for the serial shifter.
// Counts 0..2*DIV-1 while enabled and wraps to 0. Cleared on frame
// acceptance and when the latch pulse ends.
// Ports:
//   clk, rst : system clock, async active-high reset
//   clr      : synchronous clear (priority over en)
//   en       : advance the phase
//   hi       : registered, 1 while phase >= DIV (drives the serial clock)
//   wrap     : phase is at 2*DIV-1 and counting (last cycle of a bit)
//   half_end : phase is at DIV-1 (last cycle of the low half)
module seg_phase_ctr
  import seg_pkg::*;
#(
  parameter int DIV = SEG_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hi,
  output logic wrap,
  output logic half_end
);

  localparam int PW = $clog2(2 * DIV);
  localparam logic [PW-1:0] LAST = PW'(2 * DIV - 1);
  localparam logic [PW-1:0] MID  = PW'(DIV - 1);

  logic [PW-1:0] phase_r;
  logic          hi_r;

  // Phase register with registered high-half flag; hi follows phase >= DIV
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r <= '0;
      hi_r    <= 1'b0;
    end else if (clr) begin
      phase_r <= '0;
      hi_r    <= 1'b0;
    end else if (en) begin
      if (phase_r == LAST) begin
        phase_r <= '0;
        hi_r    <= 1'b0;
      end else begin
        phase_r <= phase_r + PW'(1);
        // next phase is >= DIV exactly when the current one is >= DIV-1
        hi_r    <= (phase_r >= MID);
      end
    end else begin
      phase_r <= phase_r;
      hi_r    <= hi_r;
    end
  end

  assign hi       = hi_r;
  assign wrap     = en && (phase_r == LAST);
  assign half_end = (phase_r == MID);

endmodule

// File: rtl/seg_serial_out.sv
// seg_serial_out: parallel-to-serial shifter for the daisy-chained
// 7-segment shift registers. One start sends one WIDTH-bit frame MSB
// first on a divided serial clock, then pulses the output-latch enable.
// Ports:
//   clk, rst : system clock, async active-high reset
//   start    : frame request, only looked at in IDLE
//   par_data : frame to send, captured on the accepting edge
//   s_clk    : serial shift clock (registers sample on its rising edge)
//   s_data   : serial data, stable for the whole bit period
//   s_clrn   : active-low clear, released one edge after reset
//   s_en     : output-latch enable pulse, DIV cycles long
//   busy     : frame in progress
//   done     : one-cycle pulse when the frame completes
module seg_serial_out
  import seg_pkg::*;
#(
  parameter int WIDTH = SEG_FRAME_W,
  parameter int DIV   = SEG_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] par_data,
  output logic             s_clk,
  output logic             s_data,
  output logic             s_clrn,
  output logic             s_en,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  seg_state_t       state_r, state_n;
  logic [WIDTH-1:0] shreg_r, shreg_n;
  logic [BW-1:0]    bitcnt_r, bitcnt_n;
  logic             s_data_r, s_data_n;
  logic             s_en_r, s_en_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic             s_clrn_r;
  logic             ctr_clr_s, ctr_en_s;
  logic             hi_s, wrap_s, half_end_s;

  seg_phase_ctr #(.DIV(DIV)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .clr      (ctr_clr_s),
    .en       (ctr_en_s),
    .hi       (hi_s),
    .wrap     (wrap_s),
    .half_end (half_end_s)
  );

  // State and datapath registers; rst aborts any frame without a latch pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      shreg_r  <= '0;
      bitcnt_r <= '0;
      s_data_r <= 1'b0;
      s_en_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      s_clrn_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      shreg_r  <= shreg_n;
      bitcnt_r <= bitcnt_n;
      s_data_r <= s_data_n;
      s_en_r   <= s_en_n;
      busy_r   <= busy_n;
      done_r   <= done_n;
      s_clrn_r <= 1'b1;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state_r;
    shreg_n   = shreg_r;
    bitcnt_n  = bitcnt_r;
    s_data_n  = s_data_r;
    s_en_n    = s_en_r;
    busy_n    = busy_r;
    done_n    = 1'b0;
    ctr_clr_s = 1'b0;
    ctr_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n   = ST_SHIFT;
          shreg_n   = par_data;
          s_data_n  = par_data[WIDTH-1];
          bitcnt_n  = '0;
          busy_n    = 1'b1;
          ctr_clr_s = 1'b1;
        end else begin
          state_n   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        ctr_en_s = 1'b1;
        if (wrap_s) begin
          if (bitcnt_r == LAST_BIT) begin
            // counter wraps to phase 0 on its own, which times the latch pulse
            state_n  = ST_LATCH;
            s_en_n   = 1'b1;
            s_data_n = 1'b0;
          end else begin
            shreg_n  = {shreg_r[WIDTH-2:0], 1'b0};
            s_data_n = shreg_r[WIDTH-2];
            bitcnt_n = bitcnt_r + BW'(1);
          end
        end else begin
          state_n = ST_SHIFT;
        end
      end
      ST_LATCH: begin
        if (half_end_s) begin
          state_n   = ST_IDLE;
          s_en_n    = 1'b0;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          ctr_clr_s = 1'b1;
        end else begin
          ctr_en_s  = 1'b1;
        end
      end
      default: begin
        state_n   = ST_IDLE;
        s_en_n    = 1'b0;
        busy_n    = 1'b0;
        ctr_clr_s = 1'b1;
      end
    endcase
  end

  assign s_clk  = hi_s;
  assign s_data = s_data_r;
  assign s_clrn = s_clrn_r;
  assign s_en   = s_en_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_seg_serial_out.sv
// Testbench for seg_serial_out: instance 0 runs the default DIV=2,
// instance 1 runs DIV=1. Stimulus pushes expected frames into a
// scoreboard queue; per-instance monitors decode the serial stream and
// compare when done pulses.
module tb_seg_serial_out;

  typedef struct {
    logic [63:0] frame;
    int          busy_cyc;
    int          sen_cyc;
  } exp_t;

  logic        clk;
  logic [1:0]  rst_w;
  logic [1:0]  start_w;
  logic [63:0] par_a, par_b;
  logic [1:0]  sclk_w, sdata_w, clrn_w, sen_w, busy_w, done_w;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  seg_serial_out #(.WIDTH(64), .DIV(2)) dut_a (
    .clk(clk), .rst(rst_w[0]), .start(start_w[0]), .par_data(par_a),
    .s_clk(sclk_w[0]), .s_data(sdata_w[0]), .s_clrn(clrn_w[0]),
    .s_en(sen_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  seg_serial_out #(.WIDTH(64), .DIV(1)) dut_b (
    .clk(clk), .rst(rst_w[1]), .start(start_w[1]), .par_data(par_b),
    .s_clk(sclk_w[1]), .s_data(sdata_w[1]), .s_clrn(clrn_w[1]),
    .s_en(sen_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", tag, got, want);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Waits (bounded) for the next done pulse of instance g, stepping at least one cycle
  task automatic wait_done(input int g, input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_w[g] && n < budget);
    checks++;
    if (!done_w[g]) begin
      errors++;
      $display("FAIL %s: done not seen after %0d cycles, expected within %0d", tag, n, budget);
    end
  endtask

  task automatic push_exp(input logic [63:0] f, input int bc, input int ec);
    exp_t e;
    e.frame    = f;
    e.busy_cyc = bc;
    e.sen_cyc  = ec;
    exp_q.push_back(e);
  endtask

  // Per-instance monitor: decodes s_data on each s_clk rise and scores at done
  for (genvar g = 0; g < 2; g++) begin : g_mon
    initial begin
      logic [63:0] cap;
      int          rises, bcyc, ecyc;
      logic        prev_sclk, prev_done;
      exp_t        e;
      cap = '0; rises = 0; bcyc = 0; ecyc = 0; prev_sclk = 1'b0; prev_done = 1'b0;
      forever begin
        @(negedge clk);
        if (rst_w[g]) begin
          cap = '0; rises = 0; bcyc = 0; ecyc = 0; prev_sclk = 1'b0; prev_done = 1'b0;
        end else begin
          if (sclk_w[g] && !prev_sclk) begin
            cap = {cap[62:0], sdata_w[g]};
            rises++;
          end
          prev_sclk = sclk_w[g];
          if (busy_w[g]) bcyc++;
          if (sen_w[g])  ecyc++;
          if (prev_done) check_bit($sformatf("done_one_cycle[%0d]", g), done_w[g], 1'b0);
          if (done_w[g] && !prev_done) begin
            check_int($sformatf("done_expected[%0d]", g), (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              checks++;
              if (cap !== e.frame) begin
                errors++;
                $display("FAIL frame[%0d]: got %h, expected %h", g, cap, e.frame);
              end
              check_int($sformatf("sclk_rises[%0d]", g), rises, 64);
              check_int($sformatf("busy_cycles[%0d]", g), bcyc, e.busy_cyc);
              check_int($sformatf("sen_cycles[%0d]", g), ecyc, e.sen_cyc);
            end
            cap = '0; rises = 0; bcyc = 0; ecyc = 0;
          end
          prev_done = done_w[g];
        end
      end
    end
  end

  initial begin
    int n, r, dcnt;
    logic prev;
    checks = 0;
    errors = 0;
    rst_w = 2'b11; start_w = 2'b00; par_a = '0; par_b = '0;

    // Reset values on both instances
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_bit($sformatf("rst_sclk[%0d]", g), sclk_w[g], 1'b0);
      check_bit($sformatf("rst_sdata[%0d]", g), sdata_w[g], 1'b0);
      check_bit($sformatf("rst_clrn[%0d]", g), clrn_w[g], 1'b0);
      check_bit($sformatf("rst_sen[%0d]", g), sen_w[g], 1'b0);
      check_bit($sformatf("rst_busy[%0d]", g), busy_w[g], 1'b0);
      check_bit($sformatf("rst_done[%0d]", g), done_w[g], 1'b0);
    end
    rst_w[0] = 1'b0;
    @(negedge clk);
    check_bit("clrn_after_release", clrn_w[0], 1'b1);

    // Single frame, DIV=2: 32 ones, 31 zeros, one; busy 64*4+2, s_en 2
    par_a = 64'hFFFF_FFFF_0000_0001;
    start_w[0] = 1'b1;
    push_exp(64'hFFFF_FFFF_0000_0001, 258, 2);
    @(negedge clk);
    start_w[0] = 1'b0;
    wait_done(0, 400, "single_frame");

    // Busy-ignore: second start with zeros at cycle 10 must not alter or queue
    repeat (3) @(negedge clk);
    par_a = 64'h0123_4567_89AB_CDEF;
    start_w[0] = 1'b1;
    push_exp(64'h0123_4567_89AB_CDEF, 258, 2);
    @(negedge clk);
    start_w[0] = 1'b0;
    repeat (9) @(negedge clk);
    check_bit("busy_at_ignored_start", busy_w[0], 1'b1);
    par_a = 64'h0;
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    wait_done(0, 400, "busy_ignore_frame");
    dcnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (done_w[0]) dcnt++;
    end
    check_int("busy_ignore_no_extra_done", dcnt, 0);

    // Back-to-back: start held, frames separated by the single done/IDLE cycle
    par_a = 64'hA5A5_A5A5_A5A5_A5A5;
    start_w[0] = 1'b1;
    push_exp(64'hA5A5_A5A5_A5A5_A5A5, 258, 2);
    wait_done(0, 400, "b2b_frame1");
    push_exp(64'hA5A5_A5A5_A5A5_A5A5, 258, 2);
    @(negedge clk);
    check_bit("b2b_restart1", busy_w[0], 1'b1);
    wait_done(0, 400, "b2b_frame2");
    push_exp(64'hA5A5_A5A5_A5A5_A5A5, 258, 2);
    @(negedge clk);
    check_bit("b2b_restart2", busy_w[0], 1'b1);
    start_w[0] = 1'b0;
    wait_done(0, 400, "b2b_frame3");
    repeat (5) @(negedge clk);
    check_bit("b2b_stopped", busy_w[0], 1'b0);

    // Abort: reset while s_clk is high during bit 20
    par_a = 64'hDEAD_BEEF_0BAD_F00D;
    start_w[0] = 1'b1;
    push_exp(64'hDEAD_BEEF_0BAD_F00D, 258, 2);
    @(negedge clk);
    start_w[0] = 1'b0;
    n = 0; r = 0; prev = 1'b0;
    while (r < 21 && n < 500) begin
      @(negedge clk);
      n++;
      if (sclk_w[0] && !prev) r++;
      prev = sclk_w[0];
    end
    check_int("abort_reached_bit20", r, 21);
    rst_w[0] = 1'b1;
    #1;
    check_bit("abort_sclk", sclk_w[0], 1'b0);
    check_bit("abort_sen", sen_w[0], 1'b0);
    check_bit("abort_busy", busy_w[0], 1'b0);
    check_bit("abort_done", done_w[0], 1'b0);
    check_bit("abort_sdata", sdata_w[0], 1'b0);
    check_bit("abort_clrn", clrn_w[0], 1'b0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst_w[0] = 1'b0;
    dcnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (done_w[0]) dcnt++;
    end
    check_int("abort_no_done", dcnt, 0);
    check_bit("abort_clrn_back", clrn_w[0], 1'b1);
    par_a = 64'h0F1E_2D3C_4B5A_6978;
    start_w[0] = 1'b1;
    push_exp(64'h0F1E_2D3C_4B5A_6978, 258, 2);
    @(negedge clk);
    start_w[0] = 1'b0;
    wait_done(0, 400, "post_abort_frame");

    // DIV=1 corner: s_clk toggles each cycle, busy 64*2+1, s_en 1
    rst_w[1] = 1'b0;
    @(negedge clk);
    par_b = 64'h8000_0000_0000_0000;
    start_w[1] = 1'b1;
    push_exp(64'h8000_0000_0000_0000, 129, 1);
    @(negedge clk);
    start_w[1] = 1'b0;
    @(negedge clk);
    check_bit("div1_sclk_hi", sclk_w[1], 1'b1);
    @(negedge clk);
    check_bit("div1_sclk_lo", sclk_w[1], 1'b0);
    wait_done(1, 300, "div1_frame");

    repeat (5) @(negedge clk);
    check_int("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_serial_out.md
# seg_serial_out

Parallel-to-serial shifter that drives the board's daisy-chained 7-segment shift registers. It sits directly downstream of the 8-digit segment decoder and takes its 64-bit active-low `pattern` as `par_data`. It clocks the data out MSB first on a divided serial clock, then pulses the output-latch enable. It is a single-shot engine: one `start` produces one full 64-bit frame.

## Interface
- `WIDTH`, default 64: bits per frame; must be ≥ 2.
- `DIV`, default 2: system cycles per serial-clock half-period; must be ≥ 1.
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: frame request. Sampled only in IDLE.
- `par_data`, in, WIDTH: frame to send. Captured on the accepting edge.
- `s_clk`, out, 1: serial shift clock to the external registers.
- `s_data`, out, 1: serial data. Stable for the whole bit period.
- `s_clrn`, out, 1: active-low clear for the external registers.
- `s_en`, out, 1: output-latch / display-enable pulse.
- `busy`, out, 1: frame in progress.
- `done`, out, 1: one-cycle pulse at frame completion.

## Operation
- Reset values: `s_clk`=0, `s_data`=0, `s_clrn`=0, `s_en`=0, `busy`=0, `done`=0. State is IDLE and all counters are 0.
- `s_clrn` rises to 1 on the first clock edge after `rst` deasserts and stays at 1.
- The FSM has three states: IDLE, SHIFT, LATCH.
- IDLE → SHIFT on an edge where `start`=1. On that edge:
  - `shreg`←`par_data`, `s_data`←`par_data[WIDTH-1]`.
  - `phase`←0, `bitcnt`←0, `busy`←1.
- In SHIFT, `phase` counts 0..2·DIV−1.
  - `s_clk`=0 while `phase`<DIV and 1 while `phase`≥DIV. The external registers sample on the rising edge, which is mid-bit.
- At the SHIFT wrap (`phase`=2·DIV−1):
  - If `bitcnt`<WIDTH−1: shift `shreg` left, `s_data`← next bit, `bitcnt`+1, `phase`←0, `s_clk`←0.
  - If `bitcnt`=WIDTH−1: go to LATCH with `s_clk`←0, `s_en`←1, `phase`←0, `s_data`←0.
- LATCH: `s_en` is held for DIV cycles, then the FSM returns to IDLE. On that edge `s_en`←0, `busy`←0, `done`←1.
- `done` lasts exactly one cycle.
- `start` while `busy`=1 is ignored, not queued.
- `start` in the same cycle that `done` is high is accepted, because the FSM is already in IDLE. Back-to-back frames are therefore legal.
- `par_data` changes after acceptance have no effect on the frame in flight.
- `rst` mid-frame aborts immediately to the reset values. There is no partial `s_en` pulse and no `done`.

## Timing
- Acceptance-to-first-rising-`s_clk` latency: DIV cycles.
- Each bit spans exactly 2·DIV cycles, and there are WIDTH `s_clk` rising edges per frame.
- `busy` is high for WIDTH·2·DIV + DIV cycles. With the defaults this is 64·4+2 = 258 cycles.
- `done` is asserted on the cycle after the last `s_en` cycle, in the same cycle `busy` falls.
- Serial frequency is f_clk/(2·DIV).

## Structure
- A shared package `seg_pkg` holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, LATCH=2'd2);
  - `SEG_FRAME_W`=64;
  - the default DIV.
- The top module contains the FSM, `shreg` and `bitcnt` (width clog2(WIDTH)).
- One sub-module, `seg_phase_ctr`, is natural. It is the 0..2·DIV−1 phase counter, with outputs `hi` (phase≥DIV) and `wrap`, and it is cleared on frame acceptance.
- All outputs are registered, with no combinational paths from inputs to outputs.

## Test plan
- Reset: hold `rst` high mid-operation → all outputs are at reset values within the same cycle. After release, `s_clrn`=1 after one edge.
- Single frame, DIV=2, `par_data`=64'hFFFF_FFFF_0000_0001, `start` for 1 cycle:
  - the bench captures `s_data` on each `s_clk` rise and gets 32 ones, 31 zeros, then a one (MSB first);
  - there are exactly 64 rises;
  - `busy` is high 258 cycles;
  - `s_en` is high 2 cycles, then `done` pulses once.
- Busy-ignore: pulse `start` again at cycle 10 with `par_data`=0 → the frame bits are unchanged and only one `done` occurs.
- Back-to-back: hold `start`=1 continuously with 64'hA5A5_A5A5_A5A5_A5A5 → consecutive frames are separated only by the IDLE cycle. Each frame decodes to A5A5… and there is one `done` per frame.
- Abort: assert `rst` at bit 20 → `s_clk`, `s_en`, `busy` go to 0 at once and no `done` is produced. The next `start` sends a full correct frame.
- DIV=1 corner: `par_data`=64'h8000_0000_0000_0000 → `s_clk` toggles every cycle, the first captured bit is 1 and the rest are 0, and `busy` lasts 129 cycles.
